adder_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the team's single 64-bit ripple-carry adder (`adder1`: inputs `a[63:0]`, `b[63:0]`, output `sout[64:0]`) among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and holds the adder inputs stable for `ADD_CYCLES` clocks, a multicycle path that covers the long carry chain. It then registers the 65-bit sum and returns it tagged with the requester ID. The block sits between the requesting datapath units and the one shared adder instance, which it instantiates internally.

---
 rtl/adder_share_arb.sv | 133 +++++++++++++
 tb/tb_adder_share_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin arbiter sharing one 64-bit adder among N_REQ requesters
// Operands are held on the adder for ADD_CYCLES clocks before the 65-bit sum is registered.

module adder1 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [64:0] sout
);
   assign sout = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_arb #(
   parameter int N_REQ      = 4,
   parameter int ADD_CYCLES = 2,
   parameter int IDW        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*64-1:0]   req_a,
   input  logic [N_REQ*64-1:0]   req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [64:0]           rsp_sum,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);
   localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [63:0]     op_a_q, op_b_q;
   logic [IDW-1:0]  op_id_q;
   logic [IDW-1:0]  last_grant_q;
   logic            rsp_valid_q, busy_q;
   logic [64:0]     rsp_sum_q;
   logic [IDW-1:0]  rsp_id_q;

   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx, cand;
   logic [63:0]     sel_a, sel_b;
   logic [64:0]     sum_w;

   // Circular search starting just after the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDW'((int'(last_grant_q) + k) % N_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a = req_a[64*i +: 64];
            sel_b = req_b[64*i +: 64];
         end
      end
   end

   assign req_ready = (rst_n && state_q == S_IDLE && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;

   adder1 u_adder (
      .a    (op_a_q),
      .b    (op_b_q),
      .sout (sum_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_id_q      <= '0;
         last_grant_q <= IDW'(N_REQ - 1);
         rsp_valid_q  <= 1'b0;
         rsp_sum_q    <= '0;
         rsp_id_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_found) begin
                  op_a_q       <= sel_a;
                  op_b_q       <= sel_b;
                  op_id_q      <= gnt_idx;
                  last_grant_q <= gnt_idx;
                  cnt_q        <= CW'(ADD_CYCLES - 1);
                  busy_q       <= 1'b1;
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               // op_a_q/op_b_q stay frozen here: the adder output is a multicycle path.
               if (cnt_q == '0) begin
                  rsp_sum_q   <= sum_w;
                  rsp_id_q    <= op_id_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard bench for adder_share_arb
// A transaction-timeline model predicts grants and responses; a monitor pops and compares.

module tb_adder_share_arb;
   localparam int N  = 4;
   localparam int AC = 2;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid, req_ready;
   logic [N*64-1:0]   req_a, req_b;
   logic              rsp_valid, rsp_ready, busy;
   logic [64:0]       rsp_sum;
   logic [IW-1:0]     rsp_id;

   adder_share_arb #(.N_REQ(N), .ADD_CYCLES(AC), .IDW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [64:0] sum;
      int          id;
   } exp_t;

   exp_t        sb[$];
   int          glog[$];
   int          gcyc[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          hs_cyc = 0;
   logic [64:0] last_sum = '0;
   logic [IW-1:0] last_id = '0;

   bit          m_idle = 1'b1;
   bit          m_pending = 1'b0;
   int          m_due = 0;
   int          m_ptr = N - 1;
   int          g;
   logic [N-1:0] er;
   exp_t        e;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (ptr + k) % N;
         if (v[idx[IW-1:0]]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one operation at a time, response due AC+1 cycles after accept.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_sum", rsp_sum, 0);
         chk("rst_rsp_id", rsp_id, 0);
         m_idle = 1'b1;
         m_pending = 1'b0;
         m_ptr = N - 1;
         sb.delete();
      end else begin
         g = m_idle ? pick(req_valid, m_ptr) : -1;
         er = (g >= 0) ? N'(1 << g) : '0;
         chk("req_ready", req_ready, er);
         chk("busy", busy, !m_idle);
         chk("rsp_valid", rsp_valid, m_pending && cyc >= m_due);
         if (g >= 0) begin
            e.sum = {1'b0, req_a[64*g +: 64]} + {1'b0, req_b[64*g +: 64]};
            e.id  = g;
            sb.push_back(e);
            m_idle = 1'b0;
            m_pending = 1'b1;
            m_due = cyc + AC + 1;
            m_ptr = g;
         end else if (m_pending && cyc >= m_due && rsp_ready) begin
            m_pending = 1'b0;
            m_idle = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) begin
               glog.push_back(i);
               gcyc.push_back(cyc);
            end
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got sum 0x%0h id %0d, expected no response", rsp_sum, rsp_id);
            end else begin
               chk("rsp_sum", rsp_sum, sb[0].sum);
               chk("rsp_id", rsp_id, sb[0].id);
               if (rsp_ready) begin
                  last_sum = rsp_sum;
                  last_id  = rsp_id;
                  hs_cyc   = cyc;
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 7) == 0) set_op(i, '1, {$urandom, $urandom});
         else set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(m_idle && !m_pending && sb.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", (m_idle && !m_pending && sb.size() == 0), 1);
   endtask

   task automatic wait_grants(input int cnt, input int budget);
      int n = 0;
      while (glog.size() < cnt && n < budget) begin
         rand_ops();
         tick();
         n++;
      end
      chk("grant_timeout", glog.size(), cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // single request
      glog.delete(); gcyc.delete();
      set_op(0, 64'd5, 64'd7);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_idle(20);
      chk("single_sum", last_sum, 65'd12);
      chk("single_id", last_id, 0);
      chk("single_ngrant", glog.size(), 1);

      // carry-out
      set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      wait_idle(20);
      chk("carry_sum", last_sum, 65'h1_FFFF_FFFF_FFFF_FFFE);
      chk("carry_id", last_id, 1);

      // pointer wrap: last grant 2, then 0 and 3 valid
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      wait_idle(20);
      glog.delete(); gcyc.delete();
      req_valid = 4'b1001;
      wait_grants(2, 30);
      req_valid = '0;
      wait_idle(20);
      if (glog.size() >= 2) begin
         chk("wrap_first", glog[0], 3);
         chk("wrap_second", glog[1], 0);
      end

      // fairness: pointer parked on 3 so order starts at 0
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      wait_idle(20);
      glog.delete(); gcyc.delete();
      req_valid = '1;
      wait_grants(6, 60);
      req_valid = '0;
      wait_idle(20);
      if (glog.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk("rr_order", glog[i], i % N);
         for (int i = 1; i < 6; i++) chk("rr_interval", gcyc[i] - gcyc[i-1], AC + 2);
      end

      // backpressure
      rsp_ready = 1'b0;
      rand_ops();
      req_valid = '1;
      tick();
      glog.delete(); gcyc.delete();
      for (int n = 0; n < 10 && !rsp_valid; n++) tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      repeat (10) tick();
      chk("bp_no_grant", glog.size(), 0);
      rsp_ready = 1'b1;
      tick();
      tick();
      chk("bp_ngrant", glog.size(), 1);
      if (glog.size() >= 1) chk("bp_grant_cycle", gcyc[0], hs_cyc + 1);
      req_valid = '0;
      wait_idle(20);

      // reset during EXEC
      rand_ops();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0101;
      tick();
      chk("exec_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_req_ready", req_ready, 0);
      chk("async_rsp_sum", rsp_sum, 0);
      chk("async_rsp_id", rsp_id, 0);
      tick();
      tick();
      glog.delete(); gcyc.delete();
      rst_n = 1'b1;
      wait_grants(1, 10);
      if (glog.size() >= 1) chk("post_reset_grant", glog[0], 0);
      req_valid = '0;
      wait_idle(20);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         rand_ops();
         req_valid = N'($urandom_range(0, 15) & $urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
